// File: rtl/merge_sort_stream.sv
// Stable bottom-up merge sorter for BWT rotation rows, sorting on a key column chosen per job (MSORT_INDEX_EN adds out_idx).
// Latency: STRING_LEN*LOG2N+1 cycles from the last input handshake to the first out_valid.
// Backpressure: in_ready is high only while loading; an output row holds while out_valid & !out_ready.
module merge_sort_stream #(
    parameter int STRING_LEN  = 8,
    parameter int COLUMN      = 3,
    parameter int ELEMENT_LEN = 8,
    localparam int LOG2N      = $clog2(STRING_LEN),
    localparam int KW         = (COLUMN > 1) ? $clog2(COLUMN) : 1,
    localparam int RW         = COLUMN * ELEMENT_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KW-1:0]    key_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_data,
    output logic             out_last,
    output logic             busy,
`ifdef MSORT_INDEX_EN
    output logic             done,
    output logic [LOG2N-1:0] out_idx
`else
    output logic             done
`endif
);

    localparam int CW = LOG2N + 1;
    localparam logic [LOG2N-1:0] LAST_ROW  = LOG2N'(STRING_LEN - 1);
    localparam logic [LOG2N-1:0] LAST_PASS = LOG2N'(LOG2N - 1);

    if (STRING_LEN < 2 || (STRING_LEN & (STRING_LEN - 1)) != 0) begin : g_len_check
        $error("merge_sort_stream: STRING_LEN must be a power of 2 and >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MERGE, S_DRAIN} state_t;
    state_t state, state_nx;

    // Ping-pong row buffers; A receives the load, passes alternate direction.
    logic [RW-1:0] buf_a [STRING_LEN];
    logic [RW-1:0] buf_b [STRING_LEN];
`ifdef MSORT_INDEX_EN
    logic [LOG2N-1:0] idx_a [STRING_LEN];
    logic [LOG2N-1:0] idx_b [STRING_LEN];
    logic [LOG2N-1:0] l_idx, r_idx, mrg_idx, first_idx, drain_idx;
`endif

    logic             src_is_a;
    logic [KW-1:0]    key_col;
    logic [LOG2N-1:0] wr_cnt, pass_cnt, rd_cnt, rd_next;
    logic [CW-1:0]    base, l_cnt, r_cnt, run_w;
    logic [LOG2N-1:0] l_addr, r_addr, mrg_addr;
    logic [RW-1:0]    l_row, r_row, mrg_row, first_row, drain_row;
    logic             l_has, r_has, take_l, pair_end, pass_end, last_write, out_hs;

    function automatic logic [ELEMENT_LEN-1:0] key_of(input logic [RW-1:0] row, input logic [KW-1:0] col);
        return row[int'(col) * ELEMENT_LEN +: ELEMENT_LEN];
    endfunction

    // Merge datapath: pick the head of the left or right run, left wins ties for stability.
    always_comb begin
        run_w    = CW'(1) << pass_cnt;
        l_addr   = LOG2N'(base + l_cnt);
        r_addr   = LOG2N'(base + run_w + r_cnt);
        mrg_addr = LOG2N'(base + l_cnt + r_cnt);
        l_row    = src_is_a ? buf_a[l_addr] : buf_b[l_addr];
        r_row    = src_is_a ? buf_a[r_addr] : buf_b[r_addr];
        l_has    = l_cnt < run_w;
        r_has    = r_cnt < run_w;
        take_l   = l_has && (!r_has || (key_of(l_row, key_col) <= key_of(r_row, key_col)));
        mrg_row  = take_l ? l_row : r_row;
        pair_end = (l_cnt + r_cnt + CW'(1)) == (run_w << 1);
        pass_end = mrg_addr == LAST_ROW;
        last_write = (state == S_MERGE) && pass_end && (pass_cnt == LAST_PASS);
        // first_row reads the destination of the final pass; drain_row reads it after the swap
        rd_next   = rd_cnt + LOG2N'(1);
        first_row = src_is_a ? buf_b[0] : buf_a[0];
        drain_row = src_is_a ? buf_a[rd_next] : buf_b[rd_next];
        out_hs    = out_valid && out_ready;
`ifdef MSORT_INDEX_EN
        l_idx     = src_is_a ? idx_a[l_addr] : idx_b[l_addr];
        r_idx     = src_is_a ? idx_a[r_addr] : idx_b[r_addr];
        mrg_idx   = take_l ? l_idx : r_idx;
        first_idx = src_is_a ? idx_b[0] : idx_a[0];
        drain_idx = src_is_a ? idx_a[rd_next] : idx_b[rd_next];
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  if (in_valid && wr_cnt == LAST_ROW) state_nx = S_MERGE;
            S_MERGE: if (last_write) state_nx = S_DRAIN;
            S_DRAIN: if (out_hs && out_last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State-decoded outputs; neither depends on in_valid or out_ready.
    always_comb begin
        in_ready = (state == S_LOAD);
        busy     = (state != S_IDLE);
    end

    // Job control counters and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_col   <= '0;
            wr_cnt    <= '0;
            pass_cnt  <= '0;
            base      <= '0;
            l_cnt     <= '0;
            r_cnt     <= '0;
            rd_cnt    <= '0;
            src_is_a  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
`ifdef MSORT_INDEX_EN
            out_idx   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    // out-of-range key columns fall back to column 0
                    key_col <= (int'(key_sel) < COLUMN) ? key_sel : '0;
                    wr_cnt  <= '0;
                end
                S_LOAD: if (in_valid) begin
                    wr_cnt <= wr_cnt + LOG2N'(1);
                    if (wr_cnt == LAST_ROW) begin
                        pass_cnt <= '0;
                        base     <= '0;
                        l_cnt    <= '0;
                        r_cnt    <= '0;
                        src_is_a <= 1'b1;
                    end
                end
                S_MERGE: begin
                    if (take_l) l_cnt <= l_cnt + CW'(1);
                    else        r_cnt <= r_cnt + CW'(1);
                    if (pair_end) begin
                        base  <= base + (run_w << 1);
                        l_cnt <= '0;
                        r_cnt <= '0;
                    end
                    if (pass_end) begin
                        base     <= '0;
                        pass_cnt <= pass_cnt + LOG2N'(1);
                        src_is_a <= !src_is_a;
                    end
                    if (last_write) begin
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        out_data  <= first_row;
                        rd_cnt    <= '0;
`ifdef MSORT_INDEX_EN
                        out_idx   <= first_idx;
`endif
                    end
                end
                S_DRAIN: if (out_hs) begin
                    if (out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        rd_cnt   <= rd_next;
                        out_data <= drain_row;
                        out_last <= (rd_next == LAST_ROW);
`ifdef MSORT_INDEX_EN
                        out_idx  <= drain_idx;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer writes: load into A, then one merged row per cycle into the non-source buffer.
    always_ff @(posedge clk) begin
        if (!rst && state == S_LOAD && in_valid) begin
            buf_a[wr_cnt] <= in_data;
`ifdef MSORT_INDEX_EN
            idx_a[wr_cnt] <= wr_cnt;
`endif
        end
        if (!rst && state == S_MERGE) begin
            if (src_is_a) begin
                buf_b[mrg_addr] <= mrg_row;
`ifdef MSORT_INDEX_EN
                idx_b[mrg_addr] <= mrg_idx;
`endif
            end else begin
                buf_a[mrg_addr] <= mrg_row;
`ifdef MSORT_INDEX_EN
                idx_a[mrg_addr] <= mrg_idx;
`endif
            end
        end
    end

endmodule
